// File: rtl/program_dumper.sv
// program_dumper: streams RAM words 0..count-1 out one byte at a time over a newData/ack handshake.
// Ports: clk, reset (async active-low); start/count request a dump (count clamped to 2^addrSize);
// addr/ramData read the RAM with one cycle of latency; dataOut/newData/ack carry the byte handshake;
// busy is high outside IDLE; done pulses for the single DONE cycle.
module program_dumper #(
    parameter int addrSize = 6,
    parameter int dataSize = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [addrSize:0]   count,
    input  logic                ack,
    input  logic [dataSize-1:0] ramData,
    output logic [dataSize-1:0] dataOut,
    output logic                newData,
    output logic [addrSize-1:0] addr,
    output logic                busy,
    output logic                done
);
    typedef enum logic [2:0] {IDLE, READ, LATCH, SEND, DONE} state_t;
    localparam logic [addrSize:0]   max_cnt  = {1'b1, {addrSize{1'b0}}};
    localparam logic [addrSize:0]   cnt_one  = 1;
    localparam logic [addrSize-1:0] addr_one = 1;
    state_t              state_q, state_d;
    logic [addrSize-1:0] addr_q, addr_d;
    logic [dataSize-1:0] data_q, data_d;
    logic [addrSize:0]   cnt_q, cnt_d;
    logic                new_q, new_d, busy_q, busy_d, done_q, done_d;
    // addr doubles as the word index: both start at 0 and advance together.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        new_d   = new_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                cnt_d   = count > max_cnt ? max_cnt : count;
                addr_d  = '0;
                busy_d  = 1'b1;
                done_d  = ~|count;
                state_d = ~|count ? DONE : READ;
            end
            READ: state_d = LATCH;
            LATCH: begin
                data_d  = ramData;
                new_d   = 1'b1;
                state_d = SEND;
            end
            SEND: if (ack) begin
                new_d   = 1'b0;
                done_d  = {1'b0, addr_q} == cnt_q - cnt_one;
                addr_d  = done_d ? addr_q : addr_q + addr_one;
                state_d = done_d ? DONE : READ;
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            new_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            new_q   <= new_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
    assign dataOut = data_q;
    assign newData = new_q;
    assign addr    = addr_q;
    assign busy    = busy_q;
    assign done    = done_q;
endmodule

// File: tb/tb_program_dumper.sv
// tb_program_dumper: table-driven and randomized dumps checked against a RAM-slice reference model.
module tb_program_dumper;
    logic       clk = 1'b0, reset = 1'b0, start = 1'b0, ack = 1'b0;
    logic [6:0] count = '0;
    logic [7:0] ramData = '0, dataOut;
    logic [5:0] addr;
    logic       newData, busy, done;
    logic [7:0] ram [64];
    int checks = 0, errors = 0;
    int got_b[$], got_a[$];
    int first_lat, bad_gap, unstable, fin_addr;
    bit seen;
    typedef struct {int cnt; int dly; int sidx; int sdly; bit again; int mode; int en; int el;} vec_t;
    vec_t tbl[7];

    program_dumper #(.addrSize(6), .dataSize(8)) dut (
        .clk(clk), .reset(reset), .start(start), .count(count), .ack(ack),
        .dataOut(dataOut), .newData(newData), .addr(addr), .ramData(ramData),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ramData <= ram[addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic fill(input int mode);
        int seq[7] = '{7, 8, 18, 22, 77, 123, 124};
        for (int i = 0; i < 64; i++)
            ram[i] = mode == 0 ? (i < 7 ? 8'(seq[i]) : 8'(160 + i)) : mode == 1 ? 8'(i) : 8'($urandom);
    endtask

    task automatic do_dump(input int cnt, input int dly, input int sidx, input int sdly, input bit again, input bit noise);
        int t, hold, ack_t;
        bit prev;
        logic [7:0] cur_d;
        logic [5:0] cur_a;
        got_b.delete(); got_a.delete();
        first_lat = -1; bad_gap = 0; unstable = 0; fin_addr = 0; seen = 0;
        t = 0; hold = 0; ack_t = 0; prev = 0; cur_d = '0; cur_a = '0;
        @(negedge clk); start = 1'b1; count = 7'(cnt);
        @(negedge clk); start = 1'b0;
        chk("busy_after_start", busy, 1);
        while (!seen && t < 4000) begin
            if (again && t == 5) begin start = 1'b1; count = 7'd1; end
            else start = 1'b0;
            if (done) begin seen = 1; fin_addr = addr; end
            if (newData) begin
                if (!prev) begin
                    got_b.push_back(dataOut); got_a.push_back(addr);
                    cur_d = dataOut; cur_a = addr; hold = 0;
                    if (got_b.size() == 1) first_lat = t;
                    else if (t - ack_t != 3) bad_gap++;
                end else if (dataOut !== cur_d || addr !== cur_a) unstable++;
                ack = hold >= (got_b.size() - 1 == sidx ? sdly : dly);
                if (ack) ack_t = t;
                hold++;
            end else ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            prev = newData;
            if (!seen) begin @(negedge clk); t++; end
        end
        ack = 1'b0; start = 1'b0;
        chk("done_seen", seen, 1);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
        chk("newdata_after_done", newData, 0);
    endtask

    task automatic check_dump(input int n, input int last);
        chk("byte_count", got_b.size(), n);
        for (int i = 0; i < n && i < got_b.size(); i++) begin
            chk("byte_value", got_b[i], ram[i]);
            chk("byte_addr", got_a[i], i);
        end
        if (n > 0) chk("first_latency", first_lat, 2);
        chk("ack_to_next_gap", bad_gap, 0);
        chk("send_stability", unstable, 0);
        chk("final_addr", fin_addr, last);
    endtask

    initial begin
        int hit, c, n;
        tbl[0] = '{7, 1, -1, 0, 1'b0, 0, 7, 6};
        tbl[1] = '{0, 0, -1, 0, 1'b0, 0, 0, 0};
        tbl[2] = '{3, 0, 1, 50, 1'b0, 0, 3, 2};
        tbl[3] = '{64, 0, -1, 0, 1'b0, 1, 64, 63};
        tbl[4] = '{100, 1, -1, 0, 1'b0, 1, 64, 63};
        tbl[5] = '{4, 2, -1, 0, 1'b1, 0, 4, 3};
        tbl[6] = '{1, 0, -1, 0, 1'b0, 0, 1, 0};
        fill(0);
        @(negedge clk); @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_newdata", newData, 0);
        chk("reset_addr", addr, 0);
        chk("reset_dataout", dataOut, 0);
        reset = 1'b1;
        for (int v = 0; v < 7; v++) begin
            fill(tbl[v].mode);
            do_dump(tbl[v].cnt, tbl[v].dly, tbl[v].sidx, tbl[v].sdly, tbl[v].again, 1'b0);
            check_dump(tbl[v].en, tbl[v].el);
        end
        chk("dataout_kept", dataOut, ram[0]);
        fill(0);
        @(negedge clk); start = 1'b1; count = 7'd7;
        @(negedge clk); start = 1'b0;
        hit = 0;
        for (int t = 0; t < 200 && hit == 0; t++) begin
            if (newData && dataOut == 8'd22) hit = 1;
            else begin ack = newData; @(negedge clk); end
        end
        ack = 1'b0;
        chk("reached_byte_22", hit, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_newdata", newData, 0);
        chk("async_dataout", dataOut, 0);
        chk("async_addr", addr, 0);
        chk("async_busy", busy, 0);
        chk("async_done", done, 0);
        @(negedge clk);
        chk("reset_no_done", done, 0);
        reset = 1'b1;
        do_dump(2, 0, -1, 0, 1'b0, 1'b1);
        check_dump(2, 1);
        for (int r = 0; r < 20; r++) begin
            fill(2);
            c = $urandom_range(0, 100);
            n = c > 64 ? 64 : c;
            do_dump(c, $urandom_range(0, 3), -1, 0, 1'b0, 1'b1);
            check_dump(n, n == 0 ? 0 : n - 1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
